// File: rtl/mem_pkg.sv
// Shared memory-access encodings, FSM state and byte-enable constants.
// Decode and execute import the same values so memOp/memSize stay consistent.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_LOADU = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Natural alignment check; the reserved size is never legal.
    function automatic logic access_legal(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: access_legal = 1'b1;
            SIZE_HALF: access_legal = ~offset[0];
            SIZE_WORD: access_legal = (offset == 2'b00);
            default:   access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the memory-access stage and the data memory.
interface mem_access_stage_if;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemBe;
    logic [31:0] dmemWdata;
    logic        dmemAck;
    logic [31:0] dmemRdata;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
        input  dmemAck, dmemRdata
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
        output dmemAck, dmemRdata
    );
endinterface

// File: rtl/load_aligner.sv
// Picks the addressed byte/half lane out of a read word and sign- or
// zero-extends it to 32 bits; words pass straight through.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] value
);
    logic [7:0]  lanes [4];
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rdata[8*gi +: 8];
    end

    assign byte_lane = lanes[offset];
    assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (size)
            SIZE_BYTE: value = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            SIZE_HALF: value = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default:   value = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on the req/ack bus,
// stalls upstream while a transaction is outstanding, registers the result.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         aluResult,
    input  logic [1:0]          memOp,
    input  logic [1:0]          memSize,
    input  logic [31:0]         memDin,
    input  logic [4:0]          rdIn,
    input  logic                regWriteIn,
    mem_access_stage_if.master  dmem,
    output logic                memStall,
    output logic                wbValid,
    output logic [4:0]          wbRd,
    output logic                wbRegWrite,
    output logic [31:0]         wbData,
    output logic                misalignErr,
    output logic                busErr
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    mem_op_e     op_q, op_d;
    mem_size_e   size_q, size_d;
    logic [1:0]  offset_q, offset_d;
    logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic        rw_q, rw_d, wb_rw_q, wb_rw_d;
    logic        wb_valid_q, wb_valid_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
    logic [31:0] wb_data_q, wb_data_d;

    mem_op_e     op_in;
    mem_size_e   size_in;
    logic        start_legal, timeout_now;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, load_value;

    assign op_in       = mem_op_e'(memOp);
    assign size_in     = mem_size_e'(memSize);
    assign start_legal = (op_in != MEM_NONE) && access_legal(size_in, aluResult[1:0]);
    assign timeout_now = (state_q == ST_BUSY) && !dmem.dmemAck && (cnt_q == CNT_LAST);

    // The timeout cycle releases the stall so upstream moves on with the error result.
    assign memStall = (state_q == ST_IDLE) ? start_legal
                                           : (!dmem.dmemAck && !timeout_now);

    always_comb begin
        case (size_in)
            SIZE_BYTE: begin
                be_new    = BE_BYTE << aluResult[1:0];
                wdata_new = {4{memDin[7:0]}};
            end
            SIZE_HALF: begin
                be_new    = BE_HALF << {aluResult[1], 1'b0};
                wdata_new = {2{memDin[15:0]}};
            end
            default: begin
                be_new    = BE_WORD;
                wdata_new = memDin;
            end
        endcase
    end

    load_aligner u_load_aligner (
        .rdata       (dmem.dmemRdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (op_q == MEM_LOADU),
        .value       (load_value)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        size_d     = size_q;
        offset_d   = offset_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_in == MEM_NONE) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rdIn;
                    wb_rw_d    = regWriteIn;
                    wb_data_d  = aluResult;
                end else if (!start_legal) begin
                    misalign_d = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rdIn;
                    wb_rw_d    = 1'b0;
                    wb_data_d  = 32'h0;
                end else begin
                    state_d  = ST_BUSY;
                    cnt_d    = '0;
                    req_d    = 1'b1;
                    we_d     = (op_in == MEM_STORE);
                    addr_d   = {aluResult[31:2], 2'b00};
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                    op_d     = op_in;
                    size_d   = size_in;
                    offset_d = aluResult[1:0];
                    rd_d     = rdIn;
                    rw_d     = regWriteIn;
                end
            end
            ST_BUSY: begin
                if (dmem.dmemAck) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = (op_q == MEM_STORE) ? 1'b0 : rw_q;
                    wb_data_d  = load_value;
                end else if (timeout_now) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    bus_err_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = 1'b0;
                    wb_data_d  = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            op_q       <= MEM_NONE;
            size_q     <= SIZE_BYTE;
            offset_q   <= 2'b00;
            rd_q       <= 5'd0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            size_q     <= size_d;
            offset_q   <= offset_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dmem.dmemReq   = req_q;
    assign dmem.dmemWe    = we_q;
    assign dmem.dmemAddr  = addr_q;
    assign dmem.dmemBe    = be_q;
    assign dmem.dmemWdata = wdata_q;
    assign wbValid        = wb_valid_q;
    assign wbRd           = wb_rd_q;
    assign wbRegWrite     = wb_rw_q;
    assign wbData         = wb_data_q;
    assign misalignErr    = misalign_q;
    assign busErr         = bus_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Table-driven bench for mem_access_stage: a driver applies instruction
// vectors and pushes expected writeback records; a monitor pops and compares.
module tb_mem_access_stage;
    import mem_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] aluResult = 32'h0;
    logic [1:0]  memOp = 2'b00;
    logic [1:0]  memSize = 2'b00;
    logic [31:0] memDin = 32'h0;
    logic [4:0]  rdIn = 5'd0;
    logic        regWriteIn = 1'b0;
    logic        memStall, wbValid, wbRegWrite, misalignErr, busErr;
    logic [4:0]  wbRd;
    logic [31:0] wbData;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .aluResult   (aluResult),
        .memOp       (memOp),
        .memSize     (memSize),
        .memDin      (memDin),
        .rdIn        (rdIn),
        .regWriteIn  (regWriteIn),
        .dmem        (bus),
        .memStall    (memStall),
        .wbValid     (wbValid),
        .wbRd        (wbRd),
        .wbRegWrite  (wbRegWrite),
        .wbData      (wbData),
        .misalignErr (misalignErr),
        .busErr      (busErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] din;
        logic [4:0]  rd;
        logic        rw;
        int          delay;
        logic [31:0] rdata;
        logic        start;
        logic [31:0] exp_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wb_data;
        logic        chk_data;
        logic        wb_rw;
        logic        mis;
        logic        berr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
        logic        berr;
    } wb_exp_t;

    int      checks = 0;
    int      failures = 0;
    vec_t    vecs[$];
    wb_exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr,
        input logic [31:0] din, input logic [4:0] rd, input logic rw, input int delay,
        input logic [31:0] rdata, input logic start, input logic [31:0] exp_addr,
        input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] wb_data,
        input logic chk_data, input logic wb_rw, input logic mis, input logic berr);
        vec_t v;
        v.op = op; v.size = size; v.addr = addr; v.din = din; v.rd = rd; v.rw = rw;
        v.delay = delay; v.rdata = rdata; v.start = start; v.exp_addr = exp_addr;
        v.be = be; v.wdata = wdata; v.wb_data = wb_data; v.chk_data = chk_data;
        v.wb_rw = wb_rw; v.mis = mis; v.berr = berr;
        return v;
    endfunction

    // Writeback monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (wbValid === 1'b1 || misalignErr === 1'b1 || busErr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {31'h0, wbValid}, 32'h0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_valid", {31'h0, wbValid}, 32'h1);
                chk("wb_rd", {27'h0, wbRd}, {27'h0, e.rd});
                chk("wb_regwrite", {31'h0, wbRegWrite}, {31'h0, e.rw});
                chk("misalign_err", {31'h0, misalignErr}, {31'h0, e.mis});
                chk("bus_err", {31'h0, busErr}, {31'h0, e.berr});
                if (e.chk_data) chk("wb_data", wbData, e.data);
            end
        end
    end

    task automatic drive_instr(input logic [1:0] op, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] din,
                               input logic [4:0] rd, input logic rw);
        memOp = op; memSize = size; aluResult = addr; memDin = din;
        rdIn = rd; regWriteIn = rw;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wb_exp_t e;
        drive_instr(v.op, v.size, v.addr, v.din, v.rd, v.rw);
        bus.dmemAck = 1'b0;
        e.rd = v.rd; e.rw = v.wb_rw; e.data = v.wb_data; e.chk_data = v.chk_data;
        e.mis = v.mis; e.berr = v.berr;
        sb.push_back(e);
        $display("txn %0d op=%b size=%b addr=%h din=%h delay=%0d", idx, v.op, v.size, v.addr, v.din, v.delay);
        #3;
        chk("stall_issue", {31'h0, memStall}, {31'h0, v.start});
        @(posedge clk); #1;
        if (v.start) begin
            chk("dmem_req", {31'h0, bus.dmemReq}, 32'h1);
            chk("dmem_we", {31'h0, bus.dmemWe}, {31'h0, (v.op == 2'b10)});
            chk("dmem_addr", bus.dmemAddr, v.exp_addr);
            chk("dmem_be", {28'h0, bus.dmemBe}, {28'h0, v.be});
            if (v.op == 2'b10) chk("dmem_wdata", bus.dmemWdata, v.wdata);
            for (int c = 0; c < T; c++) begin
                if (c == v.delay) begin
                    bus.dmemAck = 1'b1;
                    bus.dmemRdata = v.rdata;
                    #1;
                    chk("stall_ack", {31'h0, memStall}, 32'h0);
                    @(posedge clk); #1;
                    bus.dmemAck = 1'b0;
                    break;
                end
                if (c == T - 1) begin
                    #1;
                    chk("stall_timeout", {31'h0, memStall}, 32'h0);
                    @(posedge clk); #1;
                    break;
                end
                #1;
                chk("stall_busy", {31'h0, memStall}, 32'h1);
                chk("req_held", {31'h0, bus.dmemReq}, 32'h1);
                @(posedge clk); #1;
            end
            chk("req_drop", {31'h0, bus.dmemReq}, 32'h0);
        end else begin
            chk("no_req", {31'h0, bus.dmemReq}, 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wb_exp_t e;
        bus.dmemAck = 1'b0;
        bus.dmemRdata = 32'h0;

        vecs.push_back(mk(2'b10, 2'b00, 32'h1003, 32'h000000A5, 5'd3, 1, 2, 32'h0, 1, 32'h1000, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b01, 32'h2002, 32'h0, 5'd9, 1, 2, 32'h80011234, 1, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 1, 1, 0, 0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h2002, 32'h0, 5'd10, 1, 2, 32'h80011234, 1, 32'h2000, 4'b1100, 32'h0, 32'h00008001, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b10, 32'h3001, 32'h0, 5'd11, 1, 0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(2'b00, 2'b00, 32'h1234, 32'h0, 5'd5, 1, 0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h1234, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h4001, 32'h0, 5'd12, 1, 0, 32'h12348578, 1, 32'h4000, 4'b0010, 32'h0, 32'hFFFFFF85, 1, 1, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h4002, 32'h0, 5'd13, 1, 1, 32'h12348578, 1, 32'h4000, 4'b0100, 32'h0, 32'h00000034, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b00, 32'h4003, 32'h0, 5'd14, 1, 0, 32'h9A000000, 1, 32'h4000, 4'b1000, 32'h0, 32'hFFFFFF9A, 1, 1, 0, 0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h5000, 32'h0, 5'd15, 1, 0, 32'hDEADBEEF, 1, 32'h5000, 4'b0011, 32'h0, 32'h0000BEEF, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b01, 32'h5000, 32'h0, 5'd16, 1, 3, 32'hDEADBEEF, 1, 32'h5000, 4'b0011, 32'h0, 32'hFFFFBEEF, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b10, 32'h6004, 32'h0, 5'd17, 1, 0, 32'hCAFEF00D, 1, 32'h6004, 4'b1111, 32'h0, 32'hCAFEF00D, 1, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b01, 32'h7002, 32'h1234ABCD, 5'd18, 1, 0, 32'h0, 1, 32'h7000, 4'b1100, 32'hABCDABCD, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b01, 32'h7000, 32'h1234ABCD, 5'd19, 0, 1, 32'h0, 1, 32'h7000, 4'b0011, 32'hABCDABCD, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b10, 32'h8000, 32'h11223344, 5'd20, 0, 0, 32'h0, 1, 32'h8000, 4'b1111, 32'h11223344, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b00, 32'h9000, 32'hFFFFFF5A, 5'd21, 0, 0, 32'h0, 1, 32'h9000, 4'b0001, 32'h5A5A5A5A, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b01, 32'h2001, 32'h0, 5'd22, 1, 0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(2'b01, 2'b11, 32'h1000, 32'h0, 5'd23, 1, 0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(2'b10, 2'b10, 32'h8002, 32'hDEADBEEF, 5'd24, 0, 0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(2'b01, 2'b10, 32'hA000, 32'h0, 5'd25, 1, T - 1, 32'h01020304, 1, 32'hA000, 4'b1111, 32'h0, 32'h01020304, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b10, 32'hB000, 32'h0, 5'd26, 1, 99, 32'h0, 1, 32'hB000, 4'b1111, 32'h0, 32'h0, 1, 0, 0, 1));
        vecs.push_back(mk(2'b00, 2'b00, 32'hFFFFFFFF, 32'h0, 5'd31, 0, 0, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 32'h4000, 32'h0, 5'd27, 0, 0, 32'h000000FF, 1, 32'h4000, 4'b0001, 32'h0, 32'h000000FF, 1, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, bus.dmemReq}, 32'h0);
        chk("rst_wbvalid", {31'h0, wbValid}, 32'h0);
        chk("rst_wbdata", wbData, 32'h0);
        chk("rst_be", {28'h0, bus.dmemBe}, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset while BUSY, then a stray ack in IDLE
        $display("txn reset_in_busy");
        drive_instr(2'b01, 2'b10, 32'hC000, 32'h0, 5'd4, 1'b1);
        @(posedge clk); #1;
        chk("rb_req", {31'h0, bus.dmemReq}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive_instr(2'b00, 2'b00, 32'hCAFE0000, 32'h0, 5'd7, 1'b0);
        bus.dmemAck = 1'b1;
        bus.dmemRdata = 32'h55AA55AA;
        e.rd = 5'd7; e.rw = 1'b0; e.data = 32'hCAFE0000; e.chk_data = 1'b1; e.mis = 1'b0; e.berr = 1'b0;
        sb.push_back(e);
        chk("rb_req_drop", {31'h0, bus.dmemReq}, 32'h0);
        chk("rb_addr", bus.dmemAddr, 32'h0);
        chk("rb_wbvalid", {31'h0, wbValid}, 32'h0);
        chk("rb_wbdata", wbData, 32'h0);
        #1;
        chk("rb_stall", {31'h0, memStall}, 32'h0);
        @(posedge clk); #1;
        bus.dmemAck = 1'b0;
        chk("rb_stray_ack", {31'h0, bus.dmemReq}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sb_drained", sb.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
